maze_letter_placer: RTL and testbench

Sequencer that fills the maze with the secret word's letters plus decoy letters at the start of each round. On a `start` pulse from game control it draws LFSR values, rejects unusable cells, and writes one letter per free cell into the maze letter store. It drives the `init_maze_letters` / `ilc` load path consumed by `maze_letter`, and advances the shared `random_no` LFSR through `rand_en`.

---
 rtl/maze_pkg.sv | 34 +++
 rtl/maze_letter_placer_if.sv | 31 +++
 rtl/maze_letter_placer_in_word.sv | 24 ++
 rtl/maze_letter_placer.sv | 251 +++++++++++++++++++++++++
 tb/tb_maze_letter_placer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared maze constants, placer state encoding and cell indexing helper.
package maze_pkg;

  localparam int unsigned SIZE_Y     = 15;
  localparam int unsigned SIZE_X     = 27;
  localparam int unsigned WORD_CHARS = 12;

  localparam logic [7:0] LETTER_A = 8'h61;
  localparam logic [7:0] LETTER_Z = 8'h7a;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_DRAW,
    ST_CHECK,
    ST_SCAN,
    ST_WRITE,
    ST_FIN
  } placer_state_t;

  // One letter write into the maze letter store
  typedef struct packed {
    logic [3:0] y;
    logic [4:0] x;
    logic [7:0] letter;
  } letter_wr_t;

  // Flat bit index of cell (y,x) in the unocc/placed bitmaps
  function automatic int unsigned cell_idx(input int unsigned y, input int unsigned x,
                                           input int unsigned size_x = SIZE_X);
    return y * size_x + x;
  endfunction

endpackage

// File: rtl/maze_letter_placer_if.sv
// Game-control / LFSR / letter-store side of the letter placer.
interface maze_letter_placer_if #(
  parameter int unsigned SY = maze_pkg::SIZE_Y,
  parameter int unsigned SX = maze_pkg::SIZE_X
) ();

  logic             start;
  logic [95:0]      word;
  logic [3:0]       length;
  logic [31:0]      rand_val;   // current LFSR value
  logic [SY*SX-1:0] unocc;
  logic             rand_en;
  logic             wr_en;
  logic [3:0]       wr_y;
  logic [4:0]       wr_x;
  logic [7:0]       wr_letter;
  logic [SY*SX-1:0] placed;
  logic             busy;
  logic             done;

  modport master (
    output start, word, length, rand_val, unocc,
    input  rand_en, wr_en, wr_y, wr_x, wr_letter, placed, busy, done
  );

  modport slave (
    input  start, word, length, rand_val, unocc,
    output rand_en, wr_en, wr_y, wr_x, wr_letter, placed, busy, done
  );

endinterface

// File: rtl/maze_letter_placer_in_word.sv
// Combinational test: is a letter among the first len (clamped to 12) word chars.
module letter_in_word
  import maze_pkg::*;
(
  input  logic [8*WORD_CHARS-1:0] word_i,
  input  logic [3:0]              len_i,
  input  logic [7:0]              letter_i,
  output logic                    hit_c_o
);

  logic [3:0] len_c;

  // Clamp length, then compare against each valid char
  always_comb begin
    len_c   = (len_i > 4'(WORD_CHARS)) ? 4'(WORD_CHARS) : len_i;
    hit_c_o = 1'b0;
    for (int i = 0; i < int'(WORD_CHARS); i++) begin
      if ((4'(i) < len_c) && (word_i[8*(int'(WORD_CHARS)-1-i) +: 8] == letter_i)) begin
        hit_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_letter_placer.sv
// Places the secret word letters plus decoys into free maze cells each round.
module maze_letter_placer
  import maze_pkg::*;
#(
  parameter int unsigned SY        = SIZE_Y,
  parameter int unsigned SX        = SIZE_X,
  parameter int unsigned DECOYS    = 4,
  parameter int unsigned MAX_TRIES = 16
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  maze_letter_placer_if.slave bus
);

  localparam int unsigned NCELL = SY * SX;
  localparam int unsigned CW    = $clog2(NCELL);
  localparam int unsigned IW    = 5;
  localparam int unsigned TW    = $clog2(MAX_TRIES) + 1;

  placer_state_t    state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [3:0]       scan_y_q, scan_y_d;
  logic [4:0]       scan_x_q, scan_x_d;
  logic [7:0]       letter_q, letter_d;
  logic             ltr_ok_q, ltr_ok_d;
  logic [31:0]      dec_mask_q, dec_mask_d;
  logic [NCELL-1:0] placed_q, placed_d;
  logic             rand_en_q, rand_en_d;
  logic             wr_en_q, wr_en_d;
  letter_wr_t       wr_q, wr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]  len_c;
  logic [7:0]  chars_c [16];
  logic [7:0]  sel_char_c;
  logic        dup_c;
  logic        is_decoy_c;
  logic        list_end_c;
  logic [4:0]  dec_off_c;
  logic [7:0]  dec_letter_c;
  logic        dec_in_word_c;
  logic        dec_ok_c;
  logic [3:0]  cand_y_c;
  logic [4:0]  cand_x_c;
  logic        cand_ok_c;
  logic        scan_free_c;
  logic        scan_last_c;
  logic [25:0] used_c;
  logic [7:0]  fb_letter_c;
  logic        unused_rand_c;

  assign len_c         = (bus.length > 4'(WORD_CHARS)) ? 4'(WORD_CHARS) : bus.length;
  assign is_decoy_c    = (32'(idx_q) >= WORD_CHARS);
  assign list_end_c    = (32'(idx_q) >= WORD_CHARS + DECOYS);
  assign sel_char_c    = chars_c[idx_q[3:0]];
  assign dec_off_c     = bus.rand_val[28:24];
  assign dec_letter_c  = LETTER_A + 8'(dec_off_c);
  assign dec_ok_c      = (dec_off_c < 5'd26) && !dec_in_word_c && !dec_mask_q[dec_off_c];
  assign cand_y_c      = bus.rand_val[3:0];
  assign cand_x_c      = bus.rand_val[8:4];
  assign unused_rand_c = ^{bus.rand_val[31:29], bus.rand_val[23:9]};

  // Duplicate check: current char against the chars before it
  letter_in_word u_dup (
    .word_i   (bus.word),
    .len_i    (idx_q[3:0]),
    .letter_i (sel_char_c),
    .hit_c_o  (dup_c)
  );

  // Decoy check: drawn decoy letter against the whole (clamped) word
  letter_in_word u_dec (
    .word_i   (bus.word),
    .len_i    (len_c),
    .letter_i (dec_letter_c),
    .hit_c_o  (dec_in_word_c)
  );

  // Word chars as an array, padded to 16 so idx_q[3:0] always selects something
  always_comb begin
    for (int i = 0; i < 16; i++) chars_c[i] = 8'h00;
    for (int i = 0; i < int'(WORD_CHARS); i++) chars_c[i] = bus.word[8*(int'(WORD_CHARS)-1-i) +: 8];
  end

  // Candidate cell from the LFSR: in range, free and not yet holding a letter
  always_comb begin
    cand_ok_c = 1'b0;
    if ((32'(cand_y_c) < SY) && (32'(cand_x_c) < SX)) begin
      cand_ok_c = bus.unocc[CW'(cell_idx(32'(cand_y_c), 32'(cand_x_c), SX))] &&
                  !placed_q[CW'(cell_idx(32'(cand_y_c), 32'(cand_x_c), SX))];
    end
  end

  assign scan_free_c = bus.unocc[CW'(cell_idx(32'(scan_y_q), 32'(scan_x_q), SX))] &&
                       !placed_q[CW'(cell_idx(32'(scan_y_q), 32'(scan_x_q), SX))];
  assign scan_last_c = (32'(scan_y_q) == SY - 1) && (32'(scan_x_q) == SX - 1);

  // Lowest a-z letter not in the word and not already used as a decoy
  always_comb begin
    used_c = dec_mask_q[25:0];
    for (int i = 0; i < int'(WORD_CHARS); i++) begin
      if ((4'(i) < len_c) && (chars_c[i] >= LETTER_A) && (chars_c[i] <= LETTER_Z)) begin
        used_c[5'(chars_c[i] - LETTER_A)] = 1'b1;
      end
    end
    fb_letter_c = LETTER_A;
    for (int i = 25; i >= 0; i--) begin
      if (!used_c[i]) fb_letter_c = LETTER_A + 8'(i);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tries_d    = tries_q;
    scan_y_d   = scan_y_q;
    scan_x_d   = scan_x_q;
    letter_d   = letter_q;
    ltr_ok_d   = ltr_ok_q;
    dec_mask_d = dec_mask_q;
    placed_d   = placed_q;
    rand_en_d  = 1'b0;
    wr_en_d    = 1'b0;
    wr_d       = wr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          placed_d   = '0;
          dec_mask_d = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          state_d    = ST_SEL;
        end
      end
      ST_SEL: begin
        if (list_end_c) begin
          state_d = ST_FIN;
        end else if (!is_decoy_c && (32'(idx_q) >= 32'(len_c))) begin
          idx_d = IW'(WORD_CHARS);
        end else if (!is_decoy_c && ((sel_char_c == 8'h00) || dup_c)) begin
          idx_d = idx_q + 1'b1;
        end else begin
          tries_d   = '0;
          letter_d  = sel_char_c;
          ltr_ok_d  = !is_decoy_c;
          rand_en_d = 1'b1;
          state_d   = ST_DRAW;
        end
      end
      ST_DRAW: state_d = ST_CHECK;
      ST_CHECK: begin
        if (is_decoy_c) begin
          letter_d = dec_letter_c;
          ltr_ok_d = dec_ok_c;
        end
        if (cand_ok_c && (!is_decoy_c || dec_ok_c)) begin
          wr_en_d = 1'b1;
          wr_d    = '{y: cand_y_c, x: cand_x_c, letter: (is_decoy_c ? dec_letter_c : letter_q)};
          state_d = ST_WRITE;
        end else if (32'(tries_q) + 32'd1 < MAX_TRIES) begin
          tries_d   = tries_q + 1'b1;
          rand_en_d = 1'b1;
          state_d   = ST_DRAW;
        end else begin
          scan_y_d = '0;
          scan_x_d = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_free_c) begin
          wr_en_d = 1'b1;
          wr_d    = '{y: scan_y_q, x: scan_x_q, letter: (ltr_ok_q ? letter_q : fb_letter_c)};
          state_d = ST_WRITE;
        end else if (scan_last_c) begin
          // Maze full: this letter cannot be placed, move on
          idx_d   = idx_q + 1'b1;
          state_d = ST_SEL;
        end else if (32'(scan_x_q) == SX - 1) begin
          scan_x_d = '0;
          scan_y_d = scan_y_q + 1'b1;
        end else begin
          scan_x_d = scan_x_q + 1'b1;
        end
      end
      ST_WRITE: begin
        placed_d[CW'(cell_idx(32'(wr_q.y), 32'(wr_q.x), SX))] = 1'b1;
        if (is_decoy_c) dec_mask_d[5'(wr_q.letter - LETTER_A)] = 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = ST_SEL;
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tries_q    <= '0;
      scan_y_q   <= '0;
      scan_x_q   <= '0;
      letter_q   <= '0;
      ltr_ok_q   <= 1'b0;
      dec_mask_q <= '0;
      placed_q   <= '0;
      rand_en_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tries_q    <= tries_d;
      scan_y_q   <= scan_y_d;
      scan_x_q   <= scan_x_d;
      letter_q   <= letter_d;
      ltr_ok_q   <= ltr_ok_d;
      dec_mask_q <= dec_mask_d;
      placed_q   <= placed_d;
      rand_en_q  <= rand_en_d;
      wr_en_q    <= wr_en_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rand_en   = rand_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_y      = wr_q.y;
  assign bus.wr_x      = wr_q.x;
  assign bus.wr_letter = wr_q.letter;
  assign bus.placed    = placed_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_maze_letter_placer.sv
// Directed bench for maze_letter_placer: three instances (DECOYS 0, 2, 4), each with its own LFSR.
module tb_maze_letter_placer;
  import maze_pkg::*;

  localparam int unsigned NCELL = SIZE_Y * SIZE_X;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int               sel;
  logic             start;
  logic [95:0]      word;
  logic [3:0]       length;
  logic [NCELL-1:0] unocc;
  logic [31:0]      seed;
  logic             seed_ld;
  logic             mon_clr;

  wire             rand_en_w [NDUT];
  wire             wr_en_w   [NDUT];
  wire [3:0]       wr_y_w    [NDUT];
  wire [4:0]       wr_x_w    [NDUT];
  wire [7:0]       wr_letter_w [NDUT];
  wire [NCELL-1:0] placed_w  [NDUT];
  wire             busy_w    [NDUT];
  wire             done_w    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned DEC = (g == 0) ? 0 : (g == 1) ? 2 : 4;
    maze_letter_placer_if bus ();
    logic [31:0] lfsr;
    assign bus.start    = start && (sel == g);
    assign bus.word     = word;
    assign bus.length   = length;
    assign bus.unocc    = unocc;
    assign bus.rand_val = lfsr;
    always @(posedge clk) begin
      if (seed_ld) lfsr <= seed;
      else if (bus.rand_en) lfsr <= {lfsr[30:0], 1'b0} ^ (lfsr[31] ? 32'h04c11db7 : 32'h0);
    end
    maze_letter_placer #(.SY(SIZE_Y), .SX(SIZE_X), .DECOYS(DEC), .MAX_TRIES(16)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
    );
    assign rand_en_w[g]   = bus.rand_en;
    assign wr_en_w[g]     = bus.wr_en;
    assign wr_y_w[g]      = bus.wr_y;
    assign wr_x_w[g]      = bus.wr_x;
    assign wr_letter_w[g] = bus.wr_letter;
    assign placed_w[g]    = bus.placed;
    assign busy_w[g]      = bus.busy;
    assign done_w[g]      = bus.done;
  end

  wire             rand_en_s   = rand_en_w[sel];
  wire             wr_en_s     = wr_en_w[sel];
  wire [3:0]       wr_y_s      = wr_y_w[sel];
  wire [4:0]       wr_x_s      = wr_x_w[sel];
  wire [7:0]       wr_letter_s = wr_letter_w[sel];
  wire [NCELL-1:0] placed_s    = placed_w[sel];
  wire             busy_s      = busy_w[sel];
  wire             done_s      = done_w[sel];
  wire [31:0]      wr_ci_s     = 32'(wr_y_s) * SIZE_X + 32'(wr_x_s);

  int               wr_cnt, re_cnt, cyc, first_cyc;
  logic [7:0]       first_letter;
  logic [25:0]      lmask;
  logic [NCELL-1:0] wmask;
  logic             bad_cell, bad_letter, dbl_cell;

  // Write/LFSR-advance monitor for the selected instance
  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt <= 0; re_cnt <= 0; cyc <= 0; first_cyc <= 0; first_letter <= 8'h00;
      lmask <= '0; wmask <= '0; bad_cell <= 1'b0; bad_letter <= 1'b0; dbl_cell <= 1'b0;
    end else begin
      if (busy_s) cyc <= cyc + 1;
      if (rand_en_s) re_cnt <= re_cnt + 1;
      if (wr_en_s) begin
        wr_cnt <= wr_cnt + 1;
        if (wr_cnt == 0) begin
          first_letter <= wr_letter_s;
          first_cyc    <= cyc + 1;
        end
        if (32'(wr_y_s) >= SIZE_Y || 32'(wr_x_s) >= SIZE_X) begin
          bad_cell <= 1'b1;
        end else begin
          if (!unocc[wr_ci_s]) bad_cell <= 1'b1;
          if (wmask[wr_ci_s]) dbl_cell <= 1'b1;
          wmask[wr_ci_s] <= 1'b1;
        end
        if (wr_letter_s >= LETTER_A && wr_letter_s <= LETTER_Z) lmask[5'(wr_letter_s - LETTER_A)] <= 1'b1;
        else bad_letter <= 1'b1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (!done_s && i < 20000) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq({tag, "_done"}, 64'(done_s), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy_s), 64'd0);
  endtask

  task automatic launch(input int s, input logic [95:0] w, input logic [3:0] l,
                        input logic [NCELL-1:0] u, input logic [31:0] sd);
    sel = s; word = w; length = l; unocc = u; seed = sd;
    seed_ld = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1;
    seed_ld = 1'b0; mon_clr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_round(input string tag, input int s, input logic [95:0] w, input logic [3:0] l,
                           input logic [NCELL-1:0] u, input logic [31:0] sd, input bit restart);
    launch(s, w, l, u, sd);
    if (restart) begin
      // extra start in busy cycle 3
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rand_en"}, 64'(rand_en_s), 64'd0);
    check_eq({tag, "_wr_en"}, 64'(wr_en_s), 64'd0);
    check_eq({tag, "_wr_y"}, 64'(wr_y_s), 64'd0);
    check_eq({tag, "_wr_x"}, 64'(wr_x_s), 64'd0);
    check_eq({tag, "_wr_letter"}, 64'(wr_letter_s), 64'd0);
    check_eq({tag, "_placed"}, 64'($countones(placed_s)), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy_s), 64'd0);
    check_eq({tag, "_done"}, 64'(done_s), 64'd0);
  endtask

  function automatic logic [NCELL-1:0] interior();
    logic [NCELL-1:0] u = '0;
    for (int y = 1; y < int'(SIZE_Y) - 1; y++)
      for (int x = 1; x < int'(SIZE_X) - 1; x++)
        u[y * int'(SIZE_X) + x] = 1'b1;
    return u;
  endfunction

  localparam logic [95:0] W_CAT   = {8'h63, 8'h61, 8'h74, 72'h0};
  localparam logic [95:0] W_APPLE = {8'h61, 8'h70, 8'h70, 8'h6c, 8'h65, 56'h0};
  localparam logic [95:0] W_A     = {8'h61, 88'h0};
  localparam logic [95:0] W_12    = 96'h6162636465666768696a6b6c;

  initial begin
    logic [NCELL-1:0] one_cell;
    int n;
    rst_n = 1'b1; start = 1'b0; word = '0; length = '0; unocc = '0;
    seed = 32'h1; seed_ld = 1'b0; mon_clr = 1'b1; sel = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      sel = g; #1;
      check_reset_vals($sformatf("reset%0d", g));
    end
    rst_n = 1'b1; sel = 0;
    @(posedge clk); #1;

    // "cat", no decoys, interior free
    run_round("cat", 0, W_CAT, 4'd3, interior(), 32'h1ef23, 1'b0);
    check_eq("cat_writes", 64'(wr_cnt), 64'd3);
    check_eq("cat_letters", 64'(lmask), 64'h0080005);
    check_eq("cat_cells", 64'({bad_cell, dbl_cell, bad_letter}), 64'd0);
    check_eq("cat_placed", 64'($countones(placed_s)), 64'd3);

    // "apple" with two decoys
    run_round("apple", 1, W_APPLE, 4'd5, interior(), 32'h1ef23, 1'b0);
    check_eq("apple_writes", 64'(wr_cnt), 64'd6);
    check_eq("apple_word", 64'(lmask & 26'h0008811), 64'h8811);
    check_eq("apple_distinct", 64'($countones(lmask)), 64'd6);
    check_eq("apple_cells", 64'({bad_cell, dbl_cell, bad_letter}), 64'd0);
    check_eq("apple_placed", 64'($countones(placed_s)), 64'd6);

    // Single free cell (13,25), LFSR stuck at 0: every draw misses, scan finds it
    one_cell = '0;
    one_cell[13 * 27 + 25] = 1'b1;
    run_round("scan", 0, W_A, 4'd1, one_cell, 32'h0, 1'b0);
    check_eq("scan_draws", 64'(re_cnt), 64'd16);
    check_eq("scan_writes", 64'(wr_cnt), 64'd1);
    check_eq("scan_letter", 64'(first_letter), 64'h61);
    check_eq("scan_y", 64'(wr_y_s), 64'd13);
    check_eq("scan_x", 64'(wr_x_s), 64'd25);
    check_eq("scan_latency", 64'(first_cyc), 64'd411);
    check_eq("scan_bound", 64'(first_cyc <= 16 * 2 + 405 + 2), 64'd1);

    // Start again while busy is ignored
    run_round("restart", 0, W_CAT, 4'd3, interior(), 32'h1ef23, 1'b1);
    check_eq("restart_writes", 64'(wr_cnt), 64'd3);
    check_eq("restart_placed", 64'($countones(placed_s)), 64'd3);

    // Reset during the second write
    launch(0, W_CAT, 4'd3, interior(), 32'h1ef23);
    n = 0;
    for (int i = 0; i < 2000 && n < 2; i++) begin
      if (wr_en_s) n++;
      if (n < 2) begin
        @(posedge clk); #1;
      end
    end
    check_eq("rst_second_write_seen", 64'(n), 64'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_round("after_rst", 0, W_CAT, 4'd3, interior(), 32'h5a5a3, 1'b0);
    check_eq("after_rst_first", 64'(first_letter), 64'h63);
    check_eq("after_rst_writes", 64'(wr_cnt), 64'd3);

    // length 15 clamps to 12 distinct chars
    run_round("clamp", 0, W_12, 4'd15, interior(), 32'h1ef23, 1'b0);
    check_eq("clamp_writes", 64'(wr_cnt), 64'd12);
    check_eq("clamp_letters", 64'(lmask), 64'hfff);
    check_eq("clamp_placed", 64'($countones(placed_s)), 64'd12);

    // length 0: four decoys only
    run_round("decoys", 2, W_CAT, 4'd0, interior(), 32'h1ef23, 1'b0);
    check_eq("decoys_writes", 64'(wr_cnt), 64'd4);
    check_eq("decoys_distinct", 64'($countones(lmask)), 64'd4);
    check_eq("decoys_cells", 64'({bad_cell, dbl_cell, bad_letter}), 64'd0);
    check_eq("decoys_placed", 64'($countones(placed_s)), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
